dehaze_frame_ctrl: RTL and testbench
====================================

# dehaze_frame_ctrl

Frame-level sequencer for the dehazing pipeline. It runs two passes over each frame from the window source. Pass 1 feeds 3x3 windows to the atmospheric light estimator. Between passes it latches the final atmospheric light and inverse values. Pass 2 streams the replayed frame to the dehaze datapath with those latched values held constant. It sits between the line-buffer/frame-replay source and the ALE and transmission/recovery stages.

## Interface
- IMG_W, 512: frame width in pixels.
- IMG_H, 512: frame height in pixels. N = IMG_W*IMG_H; count width CW = $clog2(N).
- TIMEOUT_CYC, 1024: maximum DRAIN wait in cycles. Used only with the timeout macro.
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to process one frame.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on DONE.
- win_valid  in  1  source presents a 3x3 window.
- win_ready  out  1  controller accepts a window; 1 only in EST and APPLY.
- src_rewind  out  1  one-cycle pulse telling the source to replay the frame from pixel 0.
- ale_clr  out  1  one-cycle active-high synchronous clear to the ALE.
- ale_valid  out  1  ALE input_is_valid.
- ale_done  in  1  ALE done flag.
- ale_a_r/g/b  in  8 each  ALE atmospheric light values.
- ale_inv_r/g/b  in  16 each  ALE inverse values, Q0.16.
- a_r/g/b  out  8 each  latched atmospheric light.
- inv_a_r/g/b  out  16 each  latched inverse values, Q0.16.
- a_valid  out  1  latched values are valid for the current frame.
- deh_valid  out  1  window valid toward the dehaze datapath.
- err_timeout  out  1  sticky flag: ale_done was missed. Tied to 0 when the timeout macro is off.

## Operation
- States: IDLE, CLR, EST, DRAIN, LATCH, APPLY, DONE.
- IDLE: start=1 → CLR. In IDLE, a_valid is cleared when start is taken.
- CLR: drives ale_clr=1 for one cycle and zeroes the pixel counter → EST.
- EST:
  - win_ready=1; ale_valid = win_valid (combinational, aligned with the window data).
  - Counter increments on each accept.
  - The accept while count==N-1 → DRAIN; the counter returns to 0.
- DRAIN:
  - win_ready=0, ale_valid=0.
  - Waits for ale_done=1. In the same cycle it captures ale_a_*/ale_inv_* into a_*/inv_a_* → LATCH.
- LATCH: a_valid←1; src_rewind pulse → APPLY.
- APPLY:
  - win_ready=1; deh_valid = win_valid.
  - Counter increments on each accept; the accept at count==N-1 → DONE.
- DONE: frame_done=1 for one cycle → IDLE. Latched values and a_valid hold until the next start.
- start outside IDLE is ignored; it is not queued.
- win_valid outside EST/APPLY is not accepted; the source holds its data.
- Counter is CW bits unsigned and never wraps past N-1.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, err_timeout 0.
- rst_n assertion mid-frame aborts immediately. No partial latch is kept.
- start → ale_clr high on the next cycle.
- First window accepted 2 cycles after start, if win_valid is already high.
- ale_valid/deh_valid have zero latency from win_valid: combinational, gated by a registered state.
- Expected ALE latency: ale_done rises 3 cycles after the last ale_valid. Any ale_done already high in DRAIN is accepted.
- Minimum overhead between passes: DRAIN (≥1) + LATCH (1) cycles.
- Minimum frame length: 2N + 6 cycles with continuous win_valid.

## Configuration
- ALE_TIMEOUT_EN defined:
  - A CW-independent counter of $clog2(TIMEOUT_CYC+1) bits runs in DRAIN.
  - On reaching TIMEOUT_CYC without ale_done: err_timeout←1 (sticky until reset) and → IDLE, with a_valid=0 and no frame_done.
- Undefined: DRAIN waits indefinitely; err_timeout is constant 0.

## Structure
- Shared package dehaze_pkg: state enum, default IMG_W/IMG_H, and the Q0.16 inverse width constant (16).
- Single module; no sub-module. The value latch is a plain register bank inside the block.

## Test plan
- IMG_W=IMG_H=4 (N=16), continuous win_valid, ale_done modelled 3 cycles after the 16th ale_valid with a=(200,180,160), inv=(327,364,409) → exactly 16 ale_valid, one src_rewind, a_* and inv_* latched, 16 deh_valid, frame_done at cycle 2N+6.
- win_valid toggled 1/0 every cycle → still exactly 16 accepts per pass; win_ready is never high in DRAIN or LATCH.
- start pulsed during EST and during APPLY → ignored, counts unchanged, a single frame_done.
- rst_n low during APPLY at count 7 → all outputs 0 asynchronously; after release, start runs a clean frame with a_valid=0 until LATCH.
- ALE_TIMEOUT_EN with TIMEOUT_CYC=8, ale_done never asserted → err_timeout=1 after 8 DRAIN cycles, state IDLE, no frame_done.
- Two back-to-back frames with different ALE values → a_* holds frame 1 values through DONE; a_valid drops at the second start and reasserts with the frame 2 values.

Source files
------------

// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehazing frame controller: frame-state
// encoding, default frame geometry and fixed-point widths.
package dehaze_pkg;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;

  // Atmospheric light component width and Q0.16 inverse width.
  localparam int A_W   = 8;
  localparam int INV_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_EST,
    S_DRAIN,
    S_LATCH,
    S_APPLY,
    S_DONE
  } state_t;

endpackage

// File: rtl/dehaze_frame_ctrl.sv
// Two-pass frame sequencer for the dehazing pipeline.
// Pass 1 streams windows into the atmospheric light estimator, the final
// estimate is latched, and pass 2 replays the frame into the dehaze datapath
// with the latched values held constant.
// Optional build macro ALE_TIMEOUT_EN: bounds the wait for ale_done to
// TIMEOUT_CYC cycles and raises a sticky err_timeout when it is missed.
module dehaze_frame_ctrl
  import dehaze_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  input  logic             win_valid,
  output logic             win_ready,
  output logic             src_rewind,
  output logic             ale_clr,
  output logic             ale_valid,
  input  logic             ale_done,
  input  logic [A_W-1:0]   ale_a_r,
  input  logic [A_W-1:0]   ale_a_g,
  input  logic [A_W-1:0]   ale_a_b,
  input  logic [INV_W-1:0] ale_inv_r,
  input  logic [INV_W-1:0] ale_inv_g,
  input  logic [INV_W-1:0] ale_inv_b,
  output logic [A_W-1:0]   a_r,
  output logic [A_W-1:0]   a_g,
  output logic [A_W-1:0]   a_b,
  output logic [INV_W-1:0] inv_a_r,
  output logic [INV_W-1:0] inv_a_g,
  output logic [INV_W-1:0] inv_a_b,
  output logic             a_valid,
  output logic             deh_valid,
  output logic             err_timeout
);

  localparam int            N    = IMG_W * IMG_H;
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;

  // Handshake decode: zero latency from win_valid, qualified by the
  // registered state so nothing leaks out during DRAIN/LATCH.
  assign win_ready = (state == S_EST) || (state == S_APPLY);
  assign accept    = win_valid && win_ready;
  assign ale_valid = win_valid && (state == S_EST);
  assign deh_valid = win_valid && (state == S_APPLY);

`ifdef ALE_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt;
`else
  // The ALE is trusted to finish; the parameter is referenced only so both
  // builds share one parameter list.
  assign err_timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  // Frame FSM with registered pulses, pixel counter and the value latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      src_rewind <= 1'b0;
      ale_clr    <= 1'b0;
      a_valid    <= 1'b0;
      a_r        <= '0;
      a_g        <= '0;
      a_b        <= '0;
      inv_a_r    <= '0;
      inv_a_g    <= '0;
      inv_a_b    <= '0;
`ifdef ALE_TIMEOUT_EN
      to_cnt      <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every branch sees the
      // pre-edge state; the defaults below make the pulses single-cycle.
      ale_clr    <= 1'b0;
      src_rewind <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CLR;
            busy    <= 1'b1;
            ale_clr <= 1'b1;
            a_valid <= 1'b0;
          end
        end
        S_CLR: begin
          cnt   <= '0;
          state <= S_EST;
        end
        S_EST: begin
          if (accept) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (ale_done) begin
            a_r        <= ale_a_r;
            a_g        <= ale_a_g;
            a_b        <= ale_a_b;
            inv_a_r    <= ale_inv_r;
            inv_a_g    <= ale_inv_g;
            inv_a_b    <= ale_inv_b;
            src_rewind <= 1'b1;
            state      <= S_LATCH;
`ifdef ALE_TIMEOUT_EN
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            // Abandon the frame: no latch, no frame_done.
            to_cnt      <= '0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        S_LATCH: begin
          a_valid <= 1'b1;
          state   <= S_APPLY;
        end
        S_APPLY: begin
          if (accept) begin
            if (cnt == LAST) begin
              cnt        <= '0;
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Self-checking bench for dehaze_frame_ctrl on a 4x4 frame (N=16).
// A small ALE model raises ale_done 3 cycles after the 16th ale_valid and
// presents the real values only while ale_done is high.
module tb_dehaze_frame_ctrl;

  localparam int N      = 16;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, frame_done;
  logic        win_valid, win_ready;
  logic        src_rewind, ale_clr, ale_valid;
  logic        ale_done;
  logic [7:0]  ale_a_r, ale_a_g, ale_a_b;
  logic [15:0] ale_inv_r, ale_inv_g, ale_inv_b;
  logic [7:0]  a_r, a_g, a_b;
  logic [15:0] inv_a_r, inv_a_g, inv_a_b;
  logic        a_valid, deh_valid, err_timeout;

  dehaze_frame_ctrl #(.IMG_W(4), .IMG_H(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .frame_done(frame_done), .win_valid(win_valid), .win_ready(win_ready),
    .src_rewind(src_rewind), .ale_clr(ale_clr), .ale_valid(ale_valid),
    .ale_done(ale_done),
    .ale_a_r(ale_a_r), .ale_a_g(ale_a_g), .ale_a_b(ale_a_b),
    .ale_inv_r(ale_inv_r), .ale_inv_g(ale_inv_g), .ale_inv_b(ale_inv_b),
    .a_r(a_r), .a_g(a_g), .a_b(a_b),
    .inv_a_r(inv_a_r), .inv_a_g(inv_a_g), .inv_a_b(inv_a_b),
    .a_valid(a_valid), .deh_valid(deh_valid), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          toggle;    // win_valid high only on even cycles
    bit          inject;    // extra start pulses in EST and APPLY
    int          abort_at;  // assert rst_n after this many deh_valid, -1 = never
    logic [71:0] vals;      // {a_r,a_g,a_b,inv_r,inv_g,inv_b}
    int          exp_busy;  // busy cycles for the whole frame
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int failures = 0;

  // ALE model and monitor state.
  logic [71:0] good_vals;
  bit          ale_stuck;
  int          m_cnt, m_delay;
  int          cur_cyc;
  int          busy_cyc, av_cnt, av_first, dv_cnt, clr_cnt, clr_cyc;
  int          rew_cnt, fd_cnt, early_av, gap_viol;
  bit          seen_rewind, gap;
  logic [71:0] done_vals;
  logic        done_avalid;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {47'd0, busy, frame_done, win_ready, src_rewind, ale_clr, ale_valid,
            deh_valid, a_valid, err_timeout, a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b};
  endfunction

  function automatic logic [71:0] latched();
    return {a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b};
  endfunction

  function automatic logic [71:0] tail_c(input logic [71:0] v);
    return ~v;
  endfunction

  // ALE model plus per-frame monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt    = 0;
      m_delay  = 0;
      ale_done = 1'b0;
    end else begin
      if (ale_clr) begin
        m_cnt    = 0;
        m_delay  = 0;
        ale_done = 1'b0;
      end else begin
        if (m_delay > 0) begin
          m_delay--;
          if (m_delay == 0 && !ale_stuck) ale_done = 1'b1;
        end
        if (ale_valid) begin
          m_cnt++;
          if (m_cnt == N) m_delay = 3;
        end
      end
      if (busy) busy_cyc++;
      if (ale_clr) begin clr_cnt++; clr_cyc = cur_cyc; end
      if (ale_valid) begin
        if (av_cnt == 0) av_first = cur_cyc;
        av_cnt++;
      end
      if (deh_valid) dv_cnt++;
      if (frame_done) begin
        fd_cnt++;
        done_vals   = latched();
        done_avalid = a_valid;
      end
      if (busy && a_valid && !seen_rewind) early_av++;
      if (gap && win_ready) gap_viol++;
      if (src_rewind) begin rew_cnt++; seen_rewind = 1'b1; gap = 1'b0; end
      if (ale_valid && av_cnt == N) gap = 1'b1;
    end
    {ale_a_r, ale_a_g, ale_a_b, ale_inv_r, ale_inv_g, ale_inv_b} =
      ale_done ? good_vals : tail_c(good_vals);
  end

  task automatic run_frame(input vec_t v, output int cycles, output bit aborted);
    int e;
    busy_cyc = 0; av_cnt = 0; av_first = -1; dv_cnt = 0; clr_cnt = 0; clr_cyc = -1;
    rew_cnt = 0; fd_cnt = 0; early_av = 0; gap_viol = 0;
    seen_rewind = 1'b0; gap = 1'b0; done_vals = '0; done_avalid = 1'b0;
    good_vals = v.vals;
    aborted = 1'b0;
    @(posedge clk) #1;
    e = 0; cur_cyc = 0; start = 1'b1; win_valid = 1'b1;
    while (e < BUDGET) begin
      @(posedge clk) #1;
      e++;
      cur_cyc   = e;
      start     = v.inject && (e == 5 || e == 25);
      win_valid = v.toggle ? (e % 2 == 0) : 1'b1;
      if (v.abort_at >= 0 && dv_cnt == v.abort_at) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (!busy) break;
    end
    start     = 1'b0;
    cycles    = e;
    if (!aborted) win_valid = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  ab;
    string p;

    vecs[0] = '{toggle: 0, inject: 0, abort_at: -1,
                vals: {8'd200, 8'd180, 8'd160, 16'd327, 16'd364, 16'd409}, exp_busy: 38};
    vecs[1] = '{toggle: 1, inject: 0, abort_at: -1,
                vals: {8'd90, 8'd100, 8'd110, 16'd728, 16'd655, 16'd595}, exp_busy: 69};
    vecs[2] = '{toggle: 0, inject: 1, abort_at: -1,
                vals: {8'd255, 8'd1, 8'd128, 16'd257, 16'hFFFF, 16'd512}, exp_busy: 38};
    vecs[3] = '{toggle: 0, inject: 0, abort_at: 7,
                vals: {8'd11, 8'd22, 8'd33, 16'd44, 16'd55, 16'd66}, exp_busy: 38};
    vecs[4] = '{toggle: 0, inject: 0, abort_at: -1,
                vals: {8'd17, 8'd34, 8'd51, 16'd1000, 16'd2000, 16'd3000}, exp_busy: 38};

    rst_n = 1'b0; start = 1'b0; win_valid = 1'b0; ale_stuck = 1'b0;
    good_vals = '0; cur_cyc = 0;
    #12;
    check("reset_outputs", all_outs(), '0);
    @(posedge clk) #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_outputs", all_outs(), '0);

    for (int i = 0; i < 5; i++) begin
      p = $sformatf("v%0d_", i);
      run_frame(vecs[i], cyc, ab);
      if (vecs[i].abort_at >= 0) begin
        check({p, "aborted"}, {127'd0, ab}, 128'd1);
        #1 check({p, "async_reset_outputs"}, all_outs(), '0);
        @(posedge clk) #1;
        win_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk) #1;
        check({p, "post_reset_outputs"}, all_outs(), '0);
        continue;
      end
      check({p, "frame_ended"}, {127'd0, cyc < BUDGET}, 128'd1);
      check({p, "ale_valid_cnt"}, av_cnt, N);
      check({p, "clr_and_first_accept"}, {clr_cnt[7:0], clr_cyc[7:0], av_first[7:0]},
            {8'd1, 8'd1, 8'd2});
      check({p, "deh_valid_cnt"}, dv_cnt, N);
      check({p, "src_rewind_cnt"}, rew_cnt, 1);
      check({p, "frame_done_cnt"}, fd_cnt, 1);
      check({p, "busy_cycles"}, busy_cyc, vecs[i].exp_busy);
      check({p, "latched_at_done"}, done_vals, vecs[i].vals);
      check({p, "a_valid_at_done"}, {127'd0, done_avalid}, 128'd1);
      check({p, "a_valid_before_latch"}, early_av, 0);
      check({p, "win_ready_between_passes"}, gap_viol, 0);
      check({p, "err_timeout"}, {127'd0, err_timeout}, 128'd0);
      repeat (3) @(posedge clk);
      #1 check({p, "held_after_done"}, {a_valid, latched()}, {1'b1, vecs[i].vals});
    end

`ifdef ALE_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{toggle: 0, inject: 0, abort_at: -1,
             vals: {8'd5, 8'd6, 8'd7, 16'd8, 16'd9, 16'd10}, exp_busy: 25};
      ale_stuck = 1'b1;
      run_frame(tv, cyc, ab);
      check("to_frame_ended", {127'd0, cyc < BUDGET}, 128'd1);
      check("to_busy_cycles", busy_cyc, tv.exp_busy);
      check("to_err_and_flags", {busy, a_valid, err_timeout}, 3'b001);
      check("to_no_done_no_rewind", {fd_cnt[7:0], rew_cnt[7:0]}, 16'd0);
      repeat (3) @(posedge clk);
      #1 check("to_err_sticky", {127'd0, err_timeout}, 128'd1);
      ale_stuck = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
